// File: rtl/ram_pkg.sv
// Shared definitions for the byte-addressed dual-port RAM: access-size
// encodings, the default address width and the access-size to byte-count helper.
package ram_pkg;

  localparam int ADDR_W_DEFAULT = 14;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_load_ext.sv
// Combinational load extender: picks the low byte/halfword/word of a raw
// little-endian fetch and zero- or sign-extends it to 32 bits.
module ram_load_ext
  import ram_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        u_en,
  output logic [31:0] result
);

  logic [23:0] byte_fill_s;
  logic [15:0] half_fill_s;

  // Upper-bit fill and size selection; word accesses ignore u_en.
  always_comb begin
    byte_fill_s = u_en ? 24'h000000 : {24{raw[7]}};
    half_fill_s = u_en ? 16'h0000 : {16{raw[15]}};
    case (size)
      SZ_BYTE: result = {byte_fill_s, raw[7:0]};
      SZ_HALF: result = {half_fill_s, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/ram.sv
// Byte-addressed little-endian RAM with a registered instruction-fetch port
// and a registered load/store data port; addresses wrap, no alignment needed.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic              u_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_out,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_in,
  input  logic [1:0]        d_size,
  output logic [31:0]       d_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents are zero at power-up and are never touched by reset.
  logic [7:0]  mem [0:DEPTH-1] = '{default: 8'h00};

  logic [31:0] i_raw_s;
  logic [31:0] d_raw_s;
  logic [31:0] d_ext_s;
  logic [2:0]  n_bytes_s;
  logic [31:0] i_out_r;
  logic [31:0] d_out_r;

  assign n_bytes_s = size_bytes(d_size);

  // Gather four consecutive bytes for each port; the index sum wraps at ADDR_W bits.
  always_comb begin
    i_raw_s = 32'h0000_0000;
    d_raw_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      i_raw_s[8*k +: 8] = mem[i_addr + ADDR_W'(k)];
      d_raw_s[8*k +: 8] = mem[d_addr + ADDR_W'(k)];
    end
  end

  ram_load_ext u_load_ext (
    .raw    (d_raw_s),
    .size   (d_size),
    .u_en   (u_en),
    .result (d_ext_s)
  );

  // Store the low N bytes of d_in; an edge seen while reset is low stores nothing.
  always_ff @(posedge clk) begin
    if (rst_n && w_en) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(n_bytes_s)) begin
          mem[d_addr + ADDR_W'(k)] <= d_in[8*k +: 8];
        end
      end
    end
  end

  // Output registers sample pre-store contents, giving read-old-data on overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out_r <= 32'h0000_0000;
      d_out_r <= 32'h0000_0000;
    end else begin
      i_out_r <= i_raw_s;
      if (!w_en) begin
        d_out_r <= d_ext_s;
      end
    end
  end

  assign i_out = i_out_r;
  assign d_out = d_out_r;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_ram;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en;
  logic              u_en;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_out;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_in;
  logic [1:0]        d_size;
  logic [31:0]       d_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl [0:DEPTH-1];

  ram #(.ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_en),
    .u_en   (u_en),
    .i_addr (i_addr),
    .i_out  (i_out),
    .d_addr (d_addr),
    .d_in   (d_in),
    .d_size (d_size),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_fetch(input int a);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < 4; k++) v = v | (32'(mdl[(a + k) % DEPTH]) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] mdl_load(input int a, input logic [1:0] sz, input logic u);
    int n = nbytes(sz);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl[(a + k) % DEPTH]) << (8 * k));
    if (n < 4 && !u && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input int a, input logic [31:0] data, input logic [1:0] sz);
    for (int k = 0; k < nbytes(sz); k++) mdl[(a + k) % DEPTH] = data[8*k +: 8];
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int a, input logic [31:0] data, input logic [1:0] sz);
    w_en = 1'b1; d_addr = ADDR_W'(a); d_in = data; d_size = sz;
    tick();
    mdl_store(a, data, sz);
    w_en = 1'b0;
  endtask

  task automatic do_load(input int a, input logic [1:0] sz, input logic u);
    w_en = 1'b0; d_addr = ADDR_W'(a); d_size = sz; u_en = u;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 1'b0; u_en = 1'b0; i_addr = '0; d_addr = '0; d_in = 32'h0; d_size = 2'd0;
    for (int i = 0; i < 3; i++) mdl_store(4 * i, 32'h0, 2'd2);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    #2;
    n_cmp++; if (i_out !== 32'h0) begin n_err++; $display("FAIL reset_i_out got=%h exp=%h", i_out, 32'h0); end
    n_cmp++; if (d_out !== 32'h0) begin n_err++; $display("FAIL reset_d_out got=%h exp=%h", d_out, 32'h0); end
    tick(); tick();
    rst_n = 1'b1;
    #3;
    n_cmp++; if (i_out !== 32'h0 || d_out !== 32'h0) begin
      n_err++; $display("FAIL reset_hold i_out=%h d_out=%h exp=0", i_out, d_out);
    end
    tick();
  endtask

  task automatic test_half();
    logic [31:0] exp_v;
    do_store(2, 32'h0000_fefe, 2'd1);
    do_load(2, 2'd1, 1'b1);
    n_cmp++; if (d_out !== 32'h0000_fefe) begin n_err++; $display("FAIL half_zext got=%h exp=%h", d_out, 32'h0000_fefe); end
    do_load(2, 2'd1, 1'b0);
    n_cmp++; if (d_out !== 32'hffff_fefe) begin n_err++; $display("FAIL half_sext got=%h exp=%h", d_out, 32'hffff_fefe); end
    i_addr = ADDR_W'(0); tick();
    n_cmp++; if (i_out !== 32'hfefe_0000) begin n_err++; $display("FAIL half_word0 got=%h exp=%h", i_out, 32'hfefe_0000); end
    i_addr = ADDR_W'(4); tick();
    exp_v = mdl_fetch(4);
    n_cmp++; if (i_out !== exp_v) begin n_err++; $display("FAIL half_word4 got=%h exp=%h", i_out, exp_v); end
  endtask

  task automatic test_byte();
    do_store(5, 32'hdead_be80, 2'd0);
    do_load(5, 2'd0, 1'b0);
    n_cmp++; if (d_out !== 32'hffff_ff80) begin n_err++; $display("FAIL byte_sext got=%h exp=%h", d_out, 32'hffff_ff80); end
    do_load(5, 2'd0, 1'b1);
    n_cmp++; if (d_out !== 32'h0000_0080) begin n_err++; $display("FAIL byte_zext got=%h exp=%h", d_out, 32'h0000_0080); end
    do_load(4, 2'd2, 1'b0);
    n_cmp++; if (d_out !== 32'h0000_8000) begin n_err++; $display("FAIL byte_neighbours got=%h exp=%h", d_out, 32'h0000_8000); end
  endtask

  task automatic test_word_fetch();
    i_addr = ADDR_W'(8);
    do_store(8, 32'h1234_5678, 2'd2);
    n_cmp++; if (i_out !== 32'h0) begin n_err++; $display("FAIL rdw_old got=%h exp=%h", i_out, 32'h0); end
    tick();
    n_cmp++; if (i_out !== 32'h1234_5678) begin n_err++; $display("FAIL word_fetch got=%h exp=%h", i_out, 32'h1234_5678); end
    do_load(9, 2'd0, 1'b1);
    n_cmp++; if (d_out !== 32'h0000_0056) begin n_err++; $display("FAIL word_byte1 got=%h exp=%h", d_out, 32'h0000_0056); end
    do_store(12, 32'hffff_ffff, 2'd2);
    n_cmp++; if (d_out !== 32'h0000_0056) begin n_err++; $display("FAIL store_hold got=%h exp=%h", d_out, 32'h0000_0056); end
    do_load(12, 2'd3, 1'b1);
    n_cmp++; if (d_out !== 32'hffff_ffff) begin n_err++; $display("FAIL word_ignores_u got=%h exp=%h", d_out, 32'hffff_ffff); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4] = '{32'hfefe, 32'habba, 32'h1313, 32'hbadd};
    for (int i = 0; i < 4; i++) begin
      do_store(2 + 4 * i, vals[i], 2'd1);
      do_load(2 + 4 * i, 2'd1, 1'b1);
      n_cmp++; if (d_out !== vals[i]) begin n_err++; $display("FAIL seq_%0d got=%h exp=%h", i, d_out, vals[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_v;
    do_store(DEPTH - 2, 32'ha1b2_c3d4, 2'd2);
    do_load(0, 2'd1, 1'b1);
    n_cmp++; if (d_out !== 32'h0000_a1b2) begin n_err++; $display("FAIL wrap_low got=%h exp=%h", d_out, 32'h0000_a1b2); end
    i_addr = ADDR_W'(DEPTH - 1); tick();
    exp_v = mdl_fetch(DEPTH - 1);
    n_cmp++; if (i_out !== exp_v) begin n_err++; $display("FAIL wrap_fetch got=%h exp=%h", i_out, exp_v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_v;
    do_load(2, 2'd1, 1'b1);
    i_addr = ADDR_W'(0); tick();
    w_en = 1'b1; d_addr = ADDR_W'(20); d_in = 32'h5a5a_5a5a; d_size = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (i_out !== 32'h0 || d_out !== 32'h0) begin
      n_err++; $display("FAIL mid_reset_async i_out=%h d_out=%h exp=0", i_out, d_out);
    end
    tick();
    w_en = 1'b0;
    rst_n = 1'b1;
    #3;
    n_cmp++; if (i_out !== 32'h0 || d_out !== 32'h0) begin
      n_err++; $display("FAIL mid_reset_hold i_out=%h d_out=%h exp=0", i_out, d_out);
    end
    do_load(20, 2'd2, 1'b1);
    exp_v = mdl_load(20, 2'd2, 1'b1);
    n_cmp++; if (d_out !== exp_v) begin n_err++; $display("FAIL store_suppressed got=%h exp=%h", d_out, exp_v); end
    do_load(2, 2'd0, 1'b1);
    n_cmp++; if (d_out !== 32'h0000_00fe) begin n_err++; $display("FAIL mem_kept got=%h exp=%h", d_out, 32'h0000_00fe); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int a, ia;
      logic [1:0] sz;
      logic u, wr;
      logic [31:0] data, exp_i, exp_d;
      a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : DEPTH - 8 + $urandom_range(0, 7);
      ia = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : DEPTH - 8 + $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      data = $urandom;
      exp_i = mdl_fetch(ia);
      exp_d = wr ? d_out : mdl_load(a, sz, u);
      w_en = wr; u_en = u; d_addr = ADDR_W'(a); d_in = data; d_size = sz; i_addr = ADDR_W'(ia);
      tick();
      if (wr) mdl_store(a, data, sz);
      w_en = 1'b0;
      n_cmp++; if (i_out !== exp_i) begin n_err++; $display("FAIL rand_fetch #%0d a=%0d got=%h exp=%h", i, ia, i_out, exp_i); end
      n_cmp++; if (d_out !== exp_d) begin n_err++; $display("FAIL rand_data #%0d a=%0d wr=%0d got=%h exp=%h", i, a, wr, d_out, exp_d); end
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_byte();
    test_word_fetch();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL be the byte-address width; memory depth 2**ADDR_W bytes (16 KiB).
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 w_en  input  1  SHALL be the data-port write enable: 1 = store, 0 = load.
REQ-005 u_en  input  1  SHALL select load extension: 1 = zero-extend, 0 = sign-extend.
REQ-006 i_addr  input  ADDR_W  SHALL be the instruction-fetch byte address.
REQ-007 i_out  output  32  SHALL be the fetched instruction word.
REQ-008 d_addr  input  ADDR_W  SHALL be the data-port byte address.
REQ-009 d_in  input  32  SHALL be the store data; only the low bytes selected by d_size are used.
REQ-010 d_size  input  2  SHALL give the access size: 0 = byte, 1 = halfword, 2 = word, 3 = word.
REQ-011 d_out  output  32  SHALL be the extended load data.

Function
REQ-012 Storage SHALL be a byte array named mem[0 .. 2**ADDR_W-1], little-endian: byte k of a word at address A lives in mem[A+k].
REQ-013 mem SHALL be initialised to all zeros at time zero.
REQ-014 On the rising edge with w_en=1, mem SHALL be written with bytes 0..N-1 of d_in at d_addr..d_addr+N-1, where N = 1, 2 or 4 per d_size.
REQ-015 A store SHALL leave all other bytes unchanged.
REQ-016 Byte addresses SHALL wrap modulo 2**ADDR_W.
REQ-017 No alignment is required; a misaligned access SHALL simply touch consecutive bytes.
REQ-018 On every rising edge, i_out SHALL register the little-endian word mem[i_addr..i_addr+3], giving 1-cycle latency.
REQ-019 The fetch port SHALL operate every cycle, independent of w_en.
REQ-020 On every rising edge with w_en=0, d_out SHALL register the N-byte load from d_addr, extended to 32 bits per u_en (1-cycle latency).
REQ-021 On cycles with w_en=1, d_out SHALL hold its previous value.
REQ-022 Read-during-write (i_addr overlapping a same-edge store) SHALL return the old (pre-store) data.
REQ-023 Sign extension SHALL copy bit 7 (byte) or bit 15 (halfword) into all upper bits.
REQ-024 A word load SHALL ignore u_en.
REQ-025 A store followed by a load of the same address on the next cycle SHALL return the new data.

Reset
REQ-026 Asserting rst_n=0 SHALL asynchronously force i_out and d_out to 32'h0.
REQ-027 Outputs SHALL hold 32'h0 until the first rising edge after rst_n deasserts.
REQ-028 Reset SHALL NOT alter mem contents.
REQ-029 A store whose edge coincides with rst_n=0 SHALL be suppressed.

Structure
REQ-030 A shared package ram_pkg SHALL hold the d_size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and the default ADDR_W.
REQ-031 One sub-module, ram_load_ext, SHALL be used: a combinational size/sign extender (raw 32-bit bytes, d_size, u_en -> 32-bit result).
REQ-032 Everything else SHALL be flat in ram.

Verification
REQ-033 Halfword store: d_size=1, d_addr=2, d_in=32'h0000fefe, w_en=1 -> mem[2]=8'hfe, mem[3]=8'hfe, mem[0,1,4..7] remain 0.
REQ-034 Halfword load of the same address: u_en=1 -> d_out=32'h0000fefe; u_en=0 -> d_out=32'hfffffefe, both one edge after the request.
REQ-035 Byte store: 8'h80 at address 5, then byte load -> u_en=0 gives 32'hffffff80, u_en=1 gives 32'h00000080.
REQ-036 Word store: 32'h12345678 at address 8 -> mem[8..11] = 78,56,34,12; with i_addr=8, i_out=32'h12345678 one edge later.
REQ-037 Sequential stores of 32'hfefe, 32'habba, 32'h1313, 32'hbadd (halfword) at addresses 2, 6, 10, 14, alternating store/load cycles -> each subsequent load returns the stored value, zero-extended.
REQ-038 With rst_n pulsed low mid-operation -> i_out and d_out drop to 0 immediately, mem[2] still 8'hfe afterwards, and loads resume correctly after release.
